// File: rtl/flow_controller.sv
// Jac1-8 instruction sequencer: owns the PC, the FETCH/EXEC/HALT phase FSM, flow-op decode and debug run/step.
// Opcode map: 0..9 NOP/ALU/VAL/SHL/SHR, 16 GOTO, 17 IFZ, 18 IFNZ, 19 IFEQ, 20 IFST, 21 IFGT; the rest reserved.
module flow_controller #(
  parameter int unsigned          PC_WIDTH      = 8,
  parameter int unsigned          NumOpCodeBits = 5,
  parameter int unsigned          NumStatusBits = 3,
  parameter logic [PC_WIDTH-1:0]  RESET_PC      = '0,
  parameter bit                   START_HALTED  = 1'b0,
  parameter int unsigned          CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run_i,
  input  logic                     step_i,
  input  logic [NumOpCodeBits-1:0] opcode_i,
  input  logic [PC_WIDTH-1:0]      literal_adr_i,
  input  logic [NumStatusBits-1:0] status_i,
  output logic [PC_WIDTH-1:0]      pc_o,
  output logic                     imem_rd_en_o,
  output logic                     commit_en_o,
  output logic                     halted_o,
  output logic                     illegal_o,
  output logic [CNT_WIDTH-1:0]     retired_o
);

  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC  = 2'b01;
  localparam logic [1:0] S_HALT  = 2'b10;
  localparam logic [1:0] S_RESET = START_HALTED ? S_HALT : S_FETCH;

  localparam logic [NumOpCodeBits-1:0] OP_GOTO = NumOpCodeBits'(16);
  localparam logic [NumOpCodeBits-1:0] OP_IFZ  = NumOpCodeBits'(17);
  localparam logic [NumOpCodeBits-1:0] OP_IFNZ = NumOpCodeBits'(18);
  localparam logic [NumOpCodeBits-1:0] OP_IFEQ = NumOpCodeBits'(19);
  localparam logic [NumOpCodeBits-1:0] OP_IFST = NumOpCodeBits'(20);
  localparam logic [NumOpCodeBits-1:0] OP_IFGT = NumOpCodeBits'(21);

  logic [1:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 illegal_q, illegal_d;
  logic                 step_q, step_d;
  logic                 commit_c;
  logic                 reserved_c;
  logic                 cond_true_c;
  logic                 run_ok_c;
  logic                 flag_z, flag_b;
  logic                 unused_status;

  assign flag_z        = status_i[0];
  assign flag_b        = status_i[1];
  assign unused_status = ^status_i[NumStatusBits-1:2];

  // Reserved ranges 0_1010..0_1111 and 1_0110..1_1111.
  assign reserved_c = ((opcode_i >= NumOpCodeBits'(10)) && (opcode_i <= NumOpCodeBits'(15)))
                   || (opcode_i >= NumOpCodeBits'(22));

  // A sticky illegal flag masks free-run; only single-step can advance.
  assign run_ok_c = run_i & ~illegal_q;

  always_comb begin
    cond_true_c = 1'b1;
    case (opcode_i)
      OP_IFZ:  cond_true_c = flag_z;
      OP_IFNZ: cond_true_c = ~flag_z;
      OP_IFEQ: cond_true_c = flag_z;
      OP_IFST: cond_true_c = flag_b;
      OP_IFGT: cond_true_c = ~flag_z & ~flag_b;
      default: cond_true_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    step_d    = step_q;
    commit_c  = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        step_d = 1'b0;
        if (reserved_c) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          commit_c  = 1'b1;
          retired_d = retired_q + CNT_WIDTH'(1);
          if (opcode_i == OP_GOTO) begin
            pc_d = literal_adr_i;
          end else if (cond_true_c) begin
            pc_d = pc_q + PC_WIDTH'(1);
          end else begin
            pc_d = pc_q + PC_WIDTH'(2);
          end
          state_d = (!run_ok_c || step_q) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (run_ok_c) begin
          state_d = S_FETCH;
        end else if (step_i) begin
          step_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      illegal_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      step_q    <= step_d;
    end
  end

  assign pc_o         = pc_q;
  assign retired_o    = retired_q;
  assign illegal_o    = illegal_q;
  assign imem_rd_en_o = (state_q == S_FETCH);
  assign halted_o     = (state_q == S_HALT);
  assign commit_en_o  = commit_c;

endmodule
